gf_op_sequencer: RTL



---
 rtl/gf_seq_pkg.sv | 24 ++
 rtl/gf_op_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gf_seq_pkg.sv
// Shared definitions for the GF(2^m) operation sequencer: opcodes, FSM states, grade width.
// Latency: none (package only).
// Backpressure: none (package only).
package gf_seq_pkg;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_SQR  = 2'd2;
    localparam logic [1:0] OP_IMUL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_CAPT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Width needed to hold a field degree 0..w inclusive.
    function automatic int gf_gw(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/gf_op_sequencer.sv
// Sequences an external GF(2^m) datapath through one or two registered passes per field op.
// Latency accept->res_valid: ADD/IMUL 3, MUL/SQR 4, grade error 1 cycle; one op in flight.
// Backpressure: result held in RESP until res_ready; req_ready low whenever not IDLE.
module gf_op_sequencer
    import gf_seq_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int GW         = gf_gw(DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    // request side
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [DATA_WIDTH-1:0]     req_a,
    input  logic [DATA_WIDTH-1:0]     req_b,
    input  logic [DATA_WIDTH:0]       req_poly,
    input  logic [GW-1:0]             req_grade,
    // response side
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH-1:0]   res_data,
    output logic                      res_err,
    output logic [15:0]               op_count,
    // datapath control
    output logic                      dp_enable,
    output logic                      dp_sum_funct,
    output logic                      dp_exp_funct,
    output logic                      dp_red_funct,
    output logic                      dp_carry_option,
    output logic [GW-1:0]             dp_polyn_grade,
    output logic [DATA_WIDTH:0]       dp_polyn_red_in,
    output logic [2*DATA_WIDTH-1:0]   dp_reduc_in,
    output logic [DATA_WIDTH-1:0]     dp_a,
    output logic [DATA_WIDTH-1:0]     dp_b,
    // datapath results
    input  logic [DATA_WIDTH-1:0]     dp_out,
    input  logic [2*DATA_WIDTH-1:0]   dp_mult_out
);

    localparam logic [GW-1:0] GRADE_MIN = GW'(2);
    localparam logic [GW-1:0] GRADE_MAX = GW'(DATA_WIDTH);

    state_t                    r_state;
    logic [1:0]                r_op;
    logic [DATA_WIDTH:0]       r_poly;
    logic [GW-1:0]             r_grade;
    logic [2*DATA_WIDTH-1:0]   r_res;
    logic                      r_err;
    logic [15:0]               r_cnt;

    logic                      r_dp_enable;
    logic                      r_dp_sum;
    logic                      r_dp_exp;
    logic                      r_dp_red;
    logic                      r_dp_carry;
    logic [GW-1:0]             r_dp_grade;
    logic [DATA_WIDTH:0]       r_dp_poly;
    logic [DATA_WIDTH-1:0]     r_dp_a;
    logic [DATA_WIDTH-1:0]     r_dp_b;

    logic [DATA_WIDTH-1:0]     w_mask;
    logic                      w_is_field;
    logic                      w_grade_bad;
    logic [DATA_WIDTH-1:0]     w_a_in;
    logic [DATA_WIDTH-1:0]     w_b_in;

    // Operand conditioning at accept: field ops keep only bits [m-1:0]; a shift of m=W yields all ones.
    always_comb begin
        w_mask      = ~({DATA_WIDTH{1'b1}} << req_grade);
        w_is_field  = (req_op != OP_IMUL);
        w_grade_bad = (req_grade < GRADE_MIN) || (req_grade > GRADE_MAX);
        w_a_in      = w_is_field ? (req_a & w_mask) : req_a;
        w_b_in      = w_is_field ? (req_b & w_mask) : req_b;
    end

    // Main FSM: request latch, registered datapath controls, result capture and response counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_poly      <= '0;
            r_grade     <= '0;
            r_res       <= '0;
            r_err       <= 1'b0;
            r_cnt       <= 16'd0;
            r_dp_enable <= 1'b0;
            r_dp_sum    <= 1'b0;
            r_dp_exp    <= 1'b0;
            r_dp_red    <= 1'b0;
            r_dp_carry  <= 1'b0;
            r_dp_grade  <= '0;
            r_dp_poly   <= '0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
        end else begin
            // Datapath controls are live only for the pass being entered; clear by default.
            r_dp_enable <= 1'b0;
            r_dp_sum    <= 1'b0;
            r_dp_exp    <= 1'b0;
            r_dp_red    <= 1'b0;
            r_dp_carry  <= 1'b0;
            r_dp_grade  <= '0;
            r_dp_poly   <= '0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_poly  <= req_poly;
                        r_grade <= req_grade;
                        if (w_is_field && w_grade_bad) begin
                            // Rejected: respond straight away, datapath untouched.
                            r_res   <= '0;
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_err       <= 1'b0;
                            r_state     <= ST_P1;
                            r_dp_enable <= 1'b1;
                            r_dp_sum    <= (req_op == OP_ADD);
                            r_dp_exp    <= (req_op == OP_SQR);
                            r_dp_carry  <= (req_op == OP_IMUL);
                            r_dp_grade  <= req_grade;
                            r_dp_poly   <= req_poly;
                            r_dp_a      <= w_a_in;
                            r_dp_b      <= w_b_in;
                        end
                    end
                end
                ST_P1: begin
                    if (r_op == OP_MUL || r_op == OP_SQR) begin
                        // Second pass reduces the product now sitting in the datapath register.
                        r_state     <= ST_P2;
                        r_dp_enable <= 1'b1;
                        r_dp_red    <= 1'b1;
                        r_dp_grade  <= r_grade;
                        r_dp_poly   <= r_poly;
                    end else begin
                        r_state <= ST_CAPT;
                    end
                end
                ST_P2: begin
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (r_op == OP_IMUL) begin
                        r_res <= dp_mult_out;
                    end else begin
                        r_res <= {{DATA_WIDTH{1'b0}}, dp_out};
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        r_cnt   <= r_cnt + 16'd1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = (r_state == ST_IDLE);
    assign res_valid       = (r_state == ST_RESP);
    assign res_data        = r_res;
    assign res_err         = r_err;
    assign op_count        = r_cnt;

    assign dp_enable       = r_dp_enable;
    assign dp_sum_funct    = r_dp_sum;
    assign dp_exp_funct    = r_dp_exp;
    assign dp_red_funct    = r_dp_red;
    assign dp_carry_option = r_dp_carry;
    assign dp_polyn_grade  = r_dp_grade;
    assign dp_polyn_red_in = r_dp_poly;
    assign dp_a            = r_dp_a;
    assign dp_b            = r_dp_b;
    // The product to reduce comes straight from the datapath register during the reduce pass.
    assign dp_reduc_in     = r_dp_red ? dp_mult_out : '0;

endmodule
